// File: rtl/cpu_pkg.sv
// Shared CPU fetch definitions: control-path (cp_type) encodings and the PC step.
// Imported by pc_unit and its testbench.
package cpu_pkg;

  localparam logic [2:0] CP_SEQ = 3'b000;
  localparam logic [2:0] CP_JR  = 3'b001;
  localparam logic [2:0] CP_J   = 3'b010;
  localparam logic [2:0] CP_BR  = 3'b011;
  localparam logic [2:0] CP_JAL = 3'b100;
  localparam logic [2:0] CP_RET = 3'b101;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Decode/branch-resolution to PC-unit bundle; master drives control, slave returns PC state.
// ras_count width is clog2(RAS_DEPTH)+1 so a full stack is representable.
interface pc_unit_if #(
  parameter int XLEN      = 32,
  parameter int IMM_W     = 16,
  parameter int ADDR_W    = 26,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic              valid;
  logic [2:0]        cp_type;
  logic [XLEN-1:0]   regs;
  logic [IMM_W-1:0]  immd;
  logic [ADDR_W-1:0] addr;
  logic              enbranch;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   npc;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_ovf;

  modport master (
    output stall, valid, cp_type, regs, immd, addr, enbranch,
    input  pc, npc, ras_count, ras_ovf
  );

  modport slave (
    input  stall, valid, cp_type, regs, immd, addr, enbranch,
    output pc, npc, ras_count, ras_ovf
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push at full overwrites the oldest entry and sets a sticky ovf.
// ptr_q addresses the next free slot, so the top is at ptr_q-1; contents are not reset.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8,
  localparam int PTR_W    = $clog2(RAS_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [XLEN-1:0]  push_dat_i,
  output logic [XLEN-1:0]  top_dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign top_ptr = ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (do_pop) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= push_dat_i;
    end
  end

  assign top_dat_o = mem_q[top_ptr];
  assign count_o   = cnt_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// Registered fetch PC with combinational next-PC select; optional RAS under `PC_RAS_EN`.
// Without PC_RAS_EN, ret acts as jr, jal acts as j, and ras_count/ras_ovf read 0.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMM_W      = 16,
  parameter int              ADDR_W     = 26,
  parameter int              BR_SHIFT   = 0,
  parameter bit              IMM_SIGNED = 1'b1,
  parameter int              RAS_DEPTH  = 8,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] seq_tgt;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jmp_tgt;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] ret_tgt;
  logic            upd;

  assign upd = bus.valid && !bus.stall;

  assign imm_ext = IMM_SIGNED ? {{(XLEN-IMM_W){bus.immd[IMM_W-1]}}, bus.immd}
                              : {{(XLEN-IMM_W){1'b0}}, bus.immd};

  // All targets wrap modulo 2^XLEN.
  assign seq_tgt = pc_q + XLEN'(PC_STEP);
  assign br_tgt  = pc_q + (imm_ext << BR_SHIFT);
  assign jmp_tgt = {pc_q[XLEN-1:ADDR_W], bus.addr};

`ifdef PC_RAS_EN
  logic [XLEN-1:0]  ras_top;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_ovf;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (upd && (bus.cp_type == CP_JAL)),
    .pop_i      (upd && (bus.cp_type == CP_RET)),
    .push_dat_i (seq_tgt),
    .top_dat_o  (ras_top),
    .count_o    (ras_cnt),
    .ovf_o      (ras_ovf)
  );

  assign ret_tgt       = (ras_cnt != '0) ? ras_top : bus.regs;
  assign bus.ras_count = ras_cnt;
  assign bus.ras_ovf   = ras_ovf;
`else
  assign ret_tgt       = bus.regs;
  assign bus.ras_count = CNT_W'(0);
  assign bus.ras_ovf   = 1'b0;
`endif

  always_comb begin
    pc_d = seq_tgt;
    if (bus.valid) begin
      case (bus.cp_type)
        CP_JR:       pc_d = bus.regs;
        CP_J,
        CP_JAL:      pc_d = jmp_tgt;
        CP_BR:       pc_d = bus.enbranch ? br_tgt : seq_tgt;
        CP_RET:      pc_d = ret_tgt;
        default:     pc_d = seq_tgt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (!bus.stall) begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc  = pc_q;
  assign bus.npc = pc_d;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; expectations adapt to whether PC_RAS_EN is defined.
module tb_pc_unit;
  import cpu_pkg::*;

  localparam int XLEN      = 32;
  localparam int IMM_W     = 16;
  localparam int ADDR_W    = 26;
  localparam int RAS_DEPTH = 8;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XLEN), .IMM_W(IMM_W), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_unit #(
    .XLEN(XLEN), .IMM_W(IMM_W), .ADDR_W(ADDR_W), .BR_SHIFT(0),
    .IMM_SIGNED(1'b1), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid    = 1'b0;
    bus.cp_type  = CP_SEQ;
    bus.enbranch = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    bus.valid   = 1'b1;
    bus.cp_type = CP_JR;
    bus.regs    = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    #12;
    n_checks++;
    if (bus.pc !== RST_PC) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc, RST_PC); end
    n_checks++;
    if (bus.ras_count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", bus.ras_count); end
    n_checks++;
    if (bus.ras_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ras_ovf); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_pc = RST_PC + 32'(4 * i);
      n_checks++;
      if (bus.pc !== exp_pc) begin n_errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, bus.pc, exp_pc); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_branch();
    set_pc(32'h0000_0200);
    bus.valid = 1'b1; bus.cp_type = CP_BR; bus.immd = 16'hFFF0; bus.enbranch = 1'b1;
    #1;
    n_checks++;
    if (bus.npc !== 32'h0000_01F0) begin n_errors++; $display("FAIL br_taken: got %h expected %h", bus.npc, 32'h1F0); end
    bus.enbranch = 1'b0;
    #1;
    n_checks++;
    if (bus.npc !== 32'h0000_0204) begin n_errors++; $display("FAIL br_not_taken: got %h expected %h", bus.npc, 32'h204); end
    bus.cp_type = 3'b110;
    #1;
    n_checks++;
    if (bus.npc !== 32'h0000_0204) begin n_errors++; $display("FAIL cp_110_seq: got %h expected %h", bus.npc, 32'h204); end
    bus.cp_type = CP_JR; bus.regs = 32'h0000_5555; bus.valid = 1'b0;
    #1;
    n_checks++;
    if (bus.npc !== 32'h0000_0204) begin n_errors++; $display("FAIL invalid_seq: got %h expected %h", bus.npc, 32'h204); end
    idle();
    set_pc(32'hFFFF_FFF8);
    bus.valid = 1'b1; bus.cp_type = CP_BR; bus.immd = 16'h0010; bus.enbranch = 1'b1;
    #1;
    n_checks++;
    if (bus.npc !== 32'h0000_0008) begin n_errors++; $display("FAIL br_wrap: got %h expected %h", bus.npc, 32'h8); end
    tick();
    n_checks++;
    if (bus.pc !== 32'h0000_0008) begin n_errors++; $display("FAIL br_pc: got %h expected %h", bus.pc, 32'h8); end
    idle();
  endtask

  task automatic test_jump();
    set_pc(32'hF000_0000);
    bus.valid = 1'b1; bus.cp_type = CP_J; bus.addr = 26'h0000ABC;
    #1;
    n_checks++;
    if (bus.npc !== 32'hF000_0ABC) begin n_errors++; $display("FAIL j_target: got %h expected %h", bus.npc, 32'hF0000ABC); end
    bus.cp_type = CP_JR; bus.regs = 32'h0000_1234;
    #1;
    n_checks++;
    if (bus.npc !== 32'h0000_1234) begin n_errors++; $display("FAIL jr_target: got %h expected %h", bus.npc, 32'h1234); end
    idle();
  endtask

  task automatic test_ras();
    logic [31:0] exp;
    set_pc(32'h0000_0040);
    bus.valid = 1'b1; bus.cp_type = CP_JAL; bus.addr = 26'h0000080;
    tick();
    n_checks++;
    if (bus.pc !== 32'h0000_0080) begin n_errors++; $display("FAIL jal_pc: got %h expected %h", bus.pc, 32'h80); end
    n_checks++;
    if (bus.ras_count !== (RAS_ON ? 4'd1 : 4'd0)) begin n_errors++; $display("FAIL jal_count: got %0d expected %0d", bus.ras_count, RAS_ON ? 1 : 0); end
    bus.cp_type = CP_RET; bus.regs = 32'h0000_0999;
    #1;
    exp = RAS_ON ? 32'h0000_0044 : 32'h0000_0999;
    n_checks++;
    if (bus.npc !== exp) begin n_errors++; $display("FAIL ret1_npc: got %h expected %h", bus.npc, exp); end
    tick();
    n_checks++;
    if (bus.ras_count !== 4'd0) begin n_errors++; $display("FAIL ret1_count: got %0d expected 0", bus.ras_count); end
    #1;
    n_checks++;
    if (bus.npc !== 32'h0000_0999) begin n_errors++; $display("FAIL ret2_npc: got %h expected %h", bus.npc, 32'h999); end
    tick();
    n_checks++;
    if (bus.ras_count !== 4'd0) begin n_errors++; $display("FAIL ret2_count: got %0d expected 0", bus.ras_count); end
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    for (int i = 0; i < 9; i++) begin
      set_pc(32'(16 * i));
      bus.valid = 1'b1; bus.cp_type = CP_JAL; bus.addr = 26'h0000500;
      tick();
      idle();
    end
    n_checks++;
    if (bus.ras_count !== (RAS_ON ? 4'd8 : 4'd0)) begin n_errors++; $display("FAIL ovf_count: got %0d expected %0d", bus.ras_count, RAS_ON ? 8 : 0); end
    n_checks++;
    if (bus.ras_ovf !== RAS_ON) begin n_errors++; $display("FAIL ovf_flag: got %b expected %b", bus.ras_ovf, RAS_ON); end
    bus.regs = 32'hDEAD_0000;
    for (int k = 0; k < 9; k++) begin
      bus.valid = 1'b1; bus.cp_type = CP_RET;
      #1;
      exp = (RAS_ON && k < 8) ? 32'(32'h84 - 16 * k) : 32'hDEAD_0000;
      n_checks++;
      if (bus.npc !== exp) begin n_errors++; $display("FAIL ovf_ret[%0d]: got %h expected %h", k, bus.npc, exp); end
      tick();
    end
    idle();
    n_checks++;
    if (bus.ras_count !== 4'd0) begin n_errors++; $display("FAIL drain_count: got %0d expected 0", bus.ras_count); end
    n_checks++;
    if (bus.ras_ovf !== RAS_ON) begin n_errors++; $display("FAIL ovf_sticky: got %b expected %b", bus.ras_ovf, RAS_ON); end
  endtask

  task automatic test_stall();
    set_pc(32'h0000_0300);
    bus.stall = 1'b1; bus.valid = 1'b1; bus.cp_type = CP_JAL; bus.addr = 26'h0000600;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.pc !== 32'h0000_0300) begin n_errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, bus.pc, 32'h300); end
      n_checks++;
      if (bus.ras_count !== 4'd0) begin n_errors++; $display("FAIL stall_count[%0d]: got %0d expected 0", i, bus.ras_count); end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.pc !== RST_PC) begin n_errors++; $display("FAIL stall_rst_pc: got %h expected %h", bus.pc, RST_PC); end
    n_checks++;
    if (bus.ras_count !== 4'd0) begin n_errors++; $display("FAIL stall_rst_count: got %0d expected 0", bus.ras_count); end
    n_checks++;
    if (bus.ras_ovf !== 1'b0) begin n_errors++; $display("FAIL stall_rst_ovf: got %b expected 0", bus.ras_ovf); end
    @(negedge clk);
    rst = 1'b0;
    bus.stall = 1'b0;
    idle();
    tick();
    n_checks++;
    if (bus.pc !== RST_PC + 32'h4) begin n_errors++; $display("FAIL post_rst_pc: got %h expected %h", bus.pc, RST_PC + 32'h4); end
  endtask

  initial begin
    bus.stall    = 1'b0;
    bus.valid    = 1'b0;
    bus.cp_type  = CP_SEQ;
    bus.regs     = '0;
    bus.immd     = '0;
    bus.addr     = '0;
    bus.enbranch = 1'b0;
    test_reset();
    test_branch();
    test_jump();
    test_ras();
    test_overflow();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the CPU fetch stage. It holds the current PC and computes the next PC for sequential flow, register jumps, absolute jumps, conditional branches, calls and returns, generalised over datapath and field widths. It adds stall handling and an optional return-address stack (RAS). It sits between decode/branch resolution and the instruction-memory address port.

## Interface
- `XLEN`, 32: PC and register width.
- `IMM_W`, 16: branch-offset field width.
- `ADDR_W`, 26: absolute jump-field width (`ADDR_W < XLEN`).
- `BR_SHIFT`, 0: left shift applied to the branch offset.
- `IMM_SIGNED`, 1: 1 sign-extends `immd`; 0 zero-extends it.
- `RAS_DEPTH`, 8: RAS entries (power of two, ≥2).
- `RESET_PC`, 0: PC value after reset.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hold the PC and RAS this cycle.
- `valid` in 1: `cp_type`/`enbranch` qualify the current instruction.
- `cp_type` in 3: 000 seq, 001 jr, 010 j, 011 branch, 100 jal, 101 ret, 11x treated as seq.
- `regs` in XLEN: register operand for jr/ret.
- `immd` in IMM_W: branch offset.
- `addr` in ADDR_W: jump field.
- `enbranch` in 1: branch taken.
- `pc` out XLEN: current PC (registered).
- `npc` out XLEN: next PC (combinational).
- `ras_count` out clog2(RAS_DEPTH)+1: valid RAS entries (0 when RAS compiled out).
- `ras_ovf` out 1: sticky, set when a push overwrites the oldest entry.

## Operation
- Sequential target: `seq = pc + 4`.
- Branch target: `br = pc + (ext(immd) << BR_SHIFT)`, where `ext` follows `IMM_SIGNED`. The sum is XLEN modulo 2^XLEN, so wrap-around past 0xFFFF_FFFF is silent.
- `npc` selection when `valid=0` or `cp_type` is 000/11x: `seq`.
- `npc` for 001 (jr): `regs`.
- `npc` for 010 (j) and 100 (jal): `{pc[XLEN-1:ADDR_W], addr}`.
- `npc` for 011 (branch): `br` if `enbranch`, else `seq`.
- `npc` for 101 (ret): RAS top if RAS is enabled and `ras_count>0`, else `regs`.
- RAS is a circular buffer with a top pointer and a count.
  - jal pushes `seq`. The pointer increments; count saturates at RAS_DEPTH. A push at full overwrites the oldest entry and sets `ras_ovf`.
  - ret with `count>0` pops: pointer decrements, count decrements. ret on an empty RAS changes no RAS state.
  - RAS updates only when `valid & !stall`.

## Timing
- Reset (async assert, sync release): `pc=RESET_PC`, `ras_count=0`, `ras_ovf=0`, RAS pointer 0. RAS contents are don't-care.
- Each rising edge with `!stall`: `pc <= npc`. With `stall`: `pc`, RAS, count and flag all hold.
- `npc` is valid in the same cycle as its inputs. `pc` reflects it one cycle later (latency 1).
- jal followed by ret in the next cycle: the ret sees the entry pushed by that jal.
- `rst` asserted mid-stall or mid-sequence overrides everything on the same cycle.
- `ras_ovf` clears only on reset.

## Configuration
- `PC_RAS_EN` defined: RAS storage and logic are present, and ret uses the RAS top when it is non-empty.
- `PC_RAS_EN` undefined: there is no RAS storage. ret behaves exactly as jr, and jal behaves exactly as j. `ras_count` is tied to 0 and `ras_ovf` to 0.

## Structure
- Shared package `cpu_pkg`: the `cp_type` encodings as named 3-bit constants (`CP_SEQ`, `CP_JR`, `CP_J`, `CP_BR`, `CP_JAL`, `CP_RET`) and the `PC_STEP`=4 constant.
- One sub-module, `pc_ras`: circular stack with push/pop/top/count/ovf, parametrised by `XLEN` and `RAS_DEPTH`. It is instantiated under `PC_RAS_EN`.

## Test plan
- Reset with `RESET_PC=0x100`, then 3 unstalled seq cycles -> `pc` = 0x100, 0x104, 0x108, 0x10C.
- `pc=0x200`, branch with `enbranch=1`, `immd=0xFFF0` (signed) -> `npc=0x1F0`. Same with `enbranch=0` -> `npc=0x204`.
- `pc=0xF000_0000`, j with `addr=0x0000ABC` -> `npc=0xF000_0ABC`. jr with `regs=0x1234` -> `npc=0x1234`.
- With `PC_RAS_EN`:
  - jal at 0x40 -> `ras_count=1`.
  - A later ret with `regs=0x999` -> `npc=0x44`, `ras_count=0`.
  - A second ret -> `npc=0x999`.
- `RAS_DEPTH=8`, 9 jals at 0x0, 0x10, …, 0x80 -> `ras_count=8`, `ras_ovf=1`. 8 rets then return 0x84, 0x74, …, 0x14.
- `stall=1` for 3 cycles during a jal -> `pc` and `ras_count` unchanged. Asserting `rst` mid-stall -> `pc=RESET_PC`, `ras_count=0` immediately.
